exu_mul_arb: RTL and testbench

Two-port arbiter and sequencer for the single multi-cycle Booth multiplier (`exu_mul`) in the execute stage. It accepts multiply requests from two issue pipes with valid/ready handshakes and grants them round-robin. It holds the multiplier's `start` for the duration of each operation and returns the result with its write-back register address to the winning pipe. Per-pipe flushes cancel an in-flight or pending operation.

---
 rtl/exu_mul_arb.sv | 139 +++++++++++++
 tb/tb_exu_mul_arb.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_mul_arb.sv
// rtl/exu_mul_arb.sv - two-pipe round-robin arbiter and sequencer for the multi-cycle multiplier
// Optional feature: MUL_ARB_RESULT_CACHE_EN adds a one-entry {op, a, b, result} cache.
module exu_mul_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [5:0]          req_op_i,
    input  logic [2*DATA_W-1:0] req_a_i,
    input  logic [2*DATA_W-1:0] req_b_i,
    input  logic [2*ADDR_W-1:0] req_waddr_i,
    input  logic [1:0]          flush_i,
    output logic [1:0]          resp_valid_o,
    input  logic [1:0]          resp_ready_i,
    output logic [DATA_W-1:0]   resp_result_o,
    output logic [ADDR_W-1:0]   resp_waddr_o,
    output logic                busy_o,
    output logic                mul_start_o,
    output logic [2:0]          mul_op_o,
    output logic [DATA_W-1:0]   mul_a_o,
    output logic [DATA_W-1:0]   mul_b_o,
    output logic [ADDR_W-1:0]   mul_waddr_o,
    input  logic [DATA_W-1:0]   mul_result_i,
    input  logic                mul_ready_i
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RESP = 2'd2} state_t;

    state_t            state;
    logic              rr_ptr;
    logic              owner;
    logic [DATA_W-1:0] result_q;

    logic [1:0]        eligible;
    logic              grant_id;
    logic              accept;
    logic              owner_flush;
    logic [2:0]        sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [ADDR_W-1:0] sel_waddr;
    logic              cache_hit;
    logic [DATA_W-1:0] cache_result;

    // A pipe flushing this cycle may not win the grant.
    assign eligible  = req_valid_i & ~flush_i;
    assign grant_id  = (&eligible) ? rr_ptr : eligible[1];
    assign accept    = rst && (state == IDLE) && (|eligible);
    assign sel_op    = grant_id ? req_op_i[5:3] : req_op_i[2:0];
    assign sel_a     = grant_id ? req_a_i[2*DATA_W-1:DATA_W] : req_a_i[DATA_W-1:0];
    assign sel_b     = grant_id ? req_b_i[2*DATA_W-1:DATA_W] : req_b_i[DATA_W-1:0];
    assign sel_waddr = grant_id ? req_waddr_i[2*ADDR_W-1:ADDR_W] : req_waddr_i[ADDR_W-1:0];

    assign owner_flush = flush_i[owner];

    assign req_ready_o   = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    // Start falls in the completion cycle so the multiplier cannot re-arm from its IDLE.
    assign mul_start_o   = (state == RUN) && !mul_ready_i && !owner_flush;
    assign resp_valid_o  = ((state == RESP) && !owner_flush) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign resp_result_o = result_q;
    assign resp_waddr_o  = mul_waddr_o;
    assign busy_o        = (state != IDLE);

`ifdef MUL_ARB_RESULT_CACHE_EN
    logic              cache_valid;
    logic [2:0]        cache_op;
    logic [DATA_W-1:0] cache_a;
    logic [DATA_W-1:0] cache_b;

    assign cache_hit = cache_valid && (cache_op == sel_op) && (cache_a == sel_a) && (cache_b == sel_b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_valid  <= 1'b0;
            cache_op     <= '0;
            cache_a      <= '0;
            cache_b      <= '0;
            cache_result <= '0;
        end else if ((state == RUN) && mul_ready_i && !owner_flush) begin
            cache_valid  <= 1'b1;
            cache_op     <= mul_op_o;
            cache_a      <= mul_a_o;
            cache_b      <= mul_b_o;
            cache_result <= mul_result_i;
        end
    end
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            result_q    <= '0;
            mul_op_o    <= '0;
            mul_a_o     <= '0;
            mul_b_o     <= '0;
            mul_waddr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner       <= grant_id;
                        rr_ptr      <= ~grant_id;
                        mul_op_o    <= sel_op;
                        mul_a_o     <= sel_a;
                        mul_b_o     <= sel_b;
                        mul_waddr_o <= sel_waddr;
                        if (cache_hit) begin
                            result_q <= cache_result;
                            state    <= RESP;
                        end else begin
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (owner_flush) begin
                        state <= IDLE;
                    end else if (mul_ready_i) begin
                        result_q <= mul_result_i;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (owner_flush || resp_ready_i[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exu_mul_arb.sv
// tb/tb_exu_mul_arb.sv - self-checking bench for exu_mul_arb with a behavioural multiplier and model
`timescale 1ns/1ps
module tb_exu_mul_arb;
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
`ifdef MUL_ARB_RESULT_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid_i = '0, flush_i = '0, resp_ready_i = '0;
    logic [5:0]  req_op_i = '0;
    logic [63:0] req_a_i = '0, req_b_i = '0;
    logic [9:0]  req_waddr_i = '0;
    logic [1:0]  req_ready_o, resp_valid_o;
    logic [31:0] resp_result_o, mul_a_o, mul_b_o, mul_result_i;
    logic [4:0]  resp_waddr_o, mul_waddr_o;
    logic [2:0]  mul_op_o;
    logic        busy_o, mul_start_o, mul_ready_i;
    logic        extra_ready = 1'b0;
    logic [5:0]  mcnt;

    int n_cmp = 0, n_bad = 0, cyc_n = 0;

    exu_mul_arb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_waddr_i(req_waddr_i), .flush_i(flush_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_result_o(resp_result_o), .resp_waddr_o(resp_waddr_o), .busy_o(busy_o),
        .mul_start_o(mul_start_o), .mul_op_o(mul_op_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_waddr_o(mul_waddr_o), .mul_result_i(mul_result_i), .mul_ready_i(mul_ready_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic [31:0] mul_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == OP_MULH || op == OP_MULHSU) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == OP_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (op == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    // Multiplier stand-in: completion pulse after 34 cycles of start held high.
    always @(posedge clk or negedge rst) begin
        if (!rst)              mcnt <= '0;
        else if (!mul_start_o) mcnt <= '0;
        else                   mcnt <= mcnt + 6'd1;
    end
    assign mul_ready_i  = (mcnt == 6'd34) || extra_ready;
    assign mul_result_i = mul_ref(mul_op_o, mul_a_o, mul_b_o);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Transaction-level reference: one outstanding op, aged in cycles since accept.
    logic        m_active = 0, m_owner = 0, m_hit = 0, m_rr = 0;
    int          m_age = 0;
    logic [2:0]  m_op = 0;
    logic [31:0] m_a = 0, m_b = 0, m_res = 0;
    logic [4:0]  m_waddr = 0;
    logic        c_valid = 0;
    logic [2:0]  c_op = 0;
    logic [31:0] c_a = 0, c_b = 0, c_res = 0;
    logic [1:0]  elig, e_ready, e_resp;
    logic        g, fl, e_start, in_resp;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_req_ready", req_ready_o, 2'b00);
            check("rst_resp_valid", resp_valid_o, 2'b00);
            check("rst_start", mul_start_o, 1'b0);
            check("rst_busy", busy_o, 1'b0);
            check("rst_mul_a", mul_a_o, 32'd0);
            check("rst_mul_b", mul_b_o, 32'd0);
            check("rst_result", resp_result_o, 32'd0);
            check("rst_waddr", resp_waddr_o, 5'd0);
            m_active = 0; m_rr = 0; c_valid = 0;
            m_op = 0; m_a = 0; m_b = 0; m_waddr = 0;
        end else begin
            e_ready = 0; e_resp = 0; e_start = 0; fl = 0; in_resp = 0; g = 0;
            elig = req_valid_i & ~flush_i;
            if (m_active) begin
                fl      = flush_i[m_owner];
                in_resp = m_hit ? (m_age >= 1) : (m_age >= 36);
                e_start = !m_hit && (m_age <= 34) && !fl;
                if (in_resp && !fl) e_resp = m_owner ? 2'b10 : 2'b01;
            end else if (elig != 2'b00) begin
                g       = (elig == 2'b11) ? m_rr : elig[1];
                e_ready = g ? 2'b10 : 2'b01;
            end
            check("req_ready", req_ready_o, e_ready);
            check("resp_valid", resp_valid_o, e_resp);
            check("mul_start", mul_start_o, e_start);
            check("busy", busy_o, m_active);
            check("mul_op", mul_op_o, m_op);
            check("mul_a", mul_a_o, m_a);
            check("mul_b", mul_b_o, m_b);
            check("mul_waddr", mul_waddr_o, m_waddr);
            if (e_resp != 2'b00) begin
                check("resp_result", resp_result_o, m_res);
                check("resp_waddr", resp_waddr_o, m_waddr);
            end
            if (m_active) begin
                if (fl) m_active = 0;
                else if (in_resp && resp_ready_i[m_owner]) m_active = 0;
                else begin
                    if (!m_hit && m_age == 35) begin
                        c_valid = 1; c_op = m_op; c_a = m_a; c_b = m_b; c_res = m_res;
                    end
                    m_age++;
                end
            end else if (elig != 2'b00) begin
                m_owner = g; m_rr = ~g;
                m_op    = req_op_i[g*3 +: 3];
                m_a     = req_a_i[g*32 +: 32];
                m_b     = req_b_i[g*32 +: 32];
                m_waddr = req_waddr_i[g*5 +: 5];
                m_hit   = CACHE_EN && c_valid && c_op == m_op && c_a == m_a && c_b == m_b;
                m_res   = m_hit ? c_res : mul_ref(m_op, m_a, m_b);
                m_active = 1; m_age = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int k, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] w);
        req_valid_i[k] = 1'b1;
        req_op_i[k*3 +: 3] = op;
        req_a_i[k*32 +: 32] = a;
        req_b_i[k*32 +: 32] = b;
        req_waddr_i[k*5 +: 5] = w;
    endtask

    task automatic wait_accept(output logic [1:0] who, output int t);
        who = 2'b00; t = 0;
        for (int i = 0; i < 100 && who == 2'b00; i++) begin
            #3;
            if (req_ready_o != 2'b00) begin who = req_ready_o; t = cyc_n; end
            tick();
        end
        if (who == 2'b00) check("accept_timeout", 1'b0, 1'b1);
    endtask

    // Returns at mid-cycle of the first response cycle.
    task automatic wait_resp(output logic [1:0] v, output logic [31:0] r, output logic [4:0] w);
        v = 2'b00; r = 0; w = 0;
        for (int i = 0; i < 100 && v == 2'b00; i++) begin
            #3;
            if (resp_valid_o != 2'b00) begin v = resp_valid_o; r = resp_result_o; w = resp_waddr_o; end
            else tick();
        end
        if (v == 2'b00) check("resp_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_timed(input int k, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] w, input logic [31:0] er);
        logic [1:0] oh;
        oh = (k == 1) ? 2'b10 : 2'b01;
        set_req(k, op, a, b, w);
        resp_ready_i = 2'b11;
        #3; check("timed_accept", req_ready_o, oh);
        tick(); req_valid_i = 2'b00;
        for (int i = 1; i <= 36; i++) begin
            #3;
            if (i == 1 || i == 34) check("timed_start_high", mul_start_o, 1'b1);
            if (i == 35) check("timed_start_low", mul_start_o, 1'b0);
            if (i == 36) begin
                check("timed_resp_valid", resp_valid_o, oh);
                check("timed_result", resp_result_o, er);
                check("timed_waddr", resp_waddr_o, w);
            end
            tick();
        end
        #3; check("timed_idle_after", busy_o, 1'b0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [1:0]  who, v;
    logic [31:0] r;
    logic [4:0]  w;
    int          t0, t1;
    logic [1:0]  grants [3];
    logic [31:0] results [3];

    initial begin
        #1 rst = 1'b0;
        repeat (3) tick();
        #3;
        check("reset_busy", busy_o, 1'b0);
        check("reset_start", mul_start_o, 1'b0);
        tick();
        rst = 1'b1;
        tick();

        // Both pipes contend for three back-to-back rounds.
        resp_ready_i = 2'b11;
        set_req(0, OP_MUL, 32'd3, 32'd4, 5'd1);
        set_req(1, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        for (int rr = 0; rr < 3; rr++) begin
            wait_accept(who, t1);
            if (rr == 0) t0 = t1;
            if (rr == 1) check("b2b_accept_spacing", t1 - t0, 37);
            if (rr == 2) req_valid_i = 2'b00;
            grants[rr] = who;
            wait_resp(v, r, w);
            results[rr] = r;
            tick();
        end
        check("grant_round0", grants[0], 2'b01);
        check("grant_round1", grants[1], 2'b10);
        check("grant_round2", grants[2], 2'b01);
        check("result_round0", results[0], 32'd12);
        check("result_mulhu_max", results[1], 32'hFFFF_FFFE);
        check("result_round2", results[2], 32'd12);
        tick();

        run_timed(0, OP_MUL, 32'd7, 32'd6, 5'd5, 32'd42);

`ifdef MUL_ARB_RESULT_CACHE_EN
        set_req(0, OP_MUL, 32'd7, 32'd6, 5'd5);
        #3; check("hit_accept", req_ready_o, 2'b01);
        tick(); req_valid_i = 2'b00;
        #3;
        check("hit_resp_valid", resp_valid_o, 2'b01);
        check("hit_result", resp_result_o, 32'd42);
        check("hit_no_start", mul_start_o, 1'b0);
        tick();
        run_timed(0, OP_MUL, 32'd7, 32'd5, 5'd5, 32'd35);
`endif

        // Owner flush mid-run; a non-owner flush earlier must be ignored.
        set_req(0, OP_MUL, 32'd100, 32'd3, 5'd7);
        #3; check("flush_accept", req_ready_o, 2'b01);
        tick(); req_valid_i = 2'b00;
        for (int i = 1; i <= 11; i++) begin
            flush_i = (i == 5) ? 2'b10 : ((i == 10) ? 2'b01 : 2'b00);
            #3;
            if (i == 5)  check("nonowner_flush_start", mul_start_o, 1'b1);
            if (i == 10) check("flush_start_drop", mul_start_o, 1'b0);
            if (i == 11) check("flush_idle", busy_o, 1'b0);
            tick();
        end
        flush_i = 2'b00;
        for (int i = 0; i < 40; i++) begin
            #3; check("flush_no_resp", resp_valid_o, 2'b00);
            tick();
        end
        set_req(0, OP_MUL, 32'd9, 32'd9, 5'd8);
        flush_i = 2'b01;
        #3; check("idle_flush_blocks_grant", req_ready_o, 2'b00);
        tick(); flush_i = 2'b00;
        wait_accept(who, t1);
        req_valid_i = 2'b00;
        wait_resp(v, r, w);
        check("after_flush_result", r, 32'd81);
        check("after_flush_waddr", w, 5'd8);
        tick();

        // Stalled response, then flush coinciding with resp_ready.
        resp_ready_i = 2'b00;
        set_req(1, OP_MUL, 32'd11, 32'd13, 5'd9);
        wait_accept(who, t1);
        req_valid_i = 2'b00;
        wait_resp(v, r, w);
        check("stall_resp_owner", v, 2'b10);
        tick();
        set_req(0, OP_MUL, 32'd2, 32'd2, 5'd3);
        for (int j = 0; j < 5; j++) begin
            #3;
            check("stall_result", resp_result_o, 32'd143);
            check("stall_waddr", resp_waddr_o, 5'd9);
            check("stall_no_ready", req_ready_o, 2'b00);
            tick();
        end
        resp_ready_i = 2'b10; flush_i = 2'b10;
        #3; check("flush_with_ready_no_resp", resp_valid_o, 2'b00);
        tick();
        flush_i = 2'b00; resp_ready_i = 2'b11;
        #3; check("accept_after_flushed_resp", req_ready_o, 2'b01);
        tick(); req_valid_i = 2'b00;
        wait_resp(v, r, w);
        check("post_stall_result", r, 32'd4);
        tick();

        // Asynchronous reset in the middle of a run.
        set_req(0, OP_MUL, 32'd5, 32'd5, 5'd4);
        #3; check("rst_test_accept", req_ready_o, 2'b01);
        tick(); req_valid_i = 2'b00;
        repeat (19) tick();
        rst = 1'b0;
        #1;
        check("async_rst_start", mul_start_o, 1'b0);
        check("async_rst_busy", busy_o, 1'b0);
        check("async_rst_mul_a", mul_a_o, 32'd0);
        tick();
        rst = 1'b1;
        extra_ready = 1'b1;
        #3; check("stray_ready_busy", busy_o, 1'b0);
        tick();
        extra_ready = 1'b0;
        #3; check("stray_ready_no_resp", resp_valid_o, 2'b00);
        tick();
        set_req(0, OP_MULH, 32'hFFFF_FFFD, 32'd5, 5'd6);
        wait_accept(who, t1);
        req_valid_i = 2'b00;
        wait_resp(v, r, w);
        check("mulh_neg_result", r, 32'hFFFF_FFFF);
        tick();
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
